// File: rtl/rf_wb_arb.sv
// Write-back arbiter and pending-write scoreboard for the 32x32 register file.
// Optional macro RF_WB_PRIO_EN: requester 0 gets fixed priority, bounded by a starvation counter.
module rf_wb_arb #(
    parameter int NREQ       = 2,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_rdy,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    output logic                 we,
    output logic [AW-1:0]        dst_addr,
    output logic [DW-1:0]        dst,
    output logic [31:0]          busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic [NREQ-1:0] cand;
    logic            hi_vld;
    int              idx;

    logic            we_p1;
    logic [AW-1:0]   dst_addr_p1;
    logic [DW-1:0]   dst_p1;
    logic [31:0]     busy_p1;
    logic [31:0]     busy_nxt;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + PW'(1);
    endfunction

`ifdef RF_WB_PRIO_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (gnt_vld && gnt_idx != '0)
            starve_cnt <= '0;
        else if (hi_vld && starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + CW'(1);
    end
`endif

    // Grant stage: round-robin search from rr_ptr over the candidate mask
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = req_vld;
        hi_vld  = |req_vld[NREQ-1:1];
`ifdef RF_WB_PRIO_EN
        // A starved upper requester masks off requester 0 for one grant.
        if (starve_cnt == CW'(STARVE_MAX) && hi_vld)
            cand[0] = 1'b0;
        else if (req_vld[0])
            cand = NREQ'(1);
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_vld && cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (!rst_n)
            gnt_vld = 1'b0;
        req_rdy = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    end

    assign gnt_addr = req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data = req_data[int'(gnt_idx)*DW +: DW];

    // A new busy_set beats a same-cycle clear: the newer op is still in flight.
    always_comb begin
        busy_nxt = busy_p1;
        if (gnt_vld)
            busy_nxt[gnt_addr] = 1'b0;
        if (busy_set)
            busy_nxt[busy_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Write stage: register the winning transfer for the register file port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_p1       <= 1'b0;
            dst_addr_p1 <= '0;
            dst_p1      <= '0;
            busy_p1     <= '0;
            rr_ptr      <= '0;
        end else begin
            we_p1   <= gnt_vld && (gnt_addr != '0);
            busy_p1 <= busy_nxt;
            if (gnt_vld && gnt_addr != '0) begin
                dst_addr_p1 <= gnt_addr;
                dst_p1      <= gnt_data;
            end
            if (gnt_vld)
                rr_ptr <= wrap_inc(gnt_idx);
        end
    end

    assign we       = we_p1;
    assign dst_addr = dst_addr_p1;
    assign dst      = dst_p1;
    assign busy     = busy_p1;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus random traffic against a behavioural model.
// Build with RF_WB_PRIO_EN defined to exercise the priority/starvation variant.
module tb_rf_wb_arb;

    localparam int NREQ       = 2;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int STARVE_MAX = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_vld;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_rdy;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic                we;
    logic [AW-1:0]       dst_addr;
    logic [DW-1:0]       dst;
    logic [31:0]         busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic [31:0] m_busy = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    rf_wb_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_addr(req_addr),
        .req_data(req_data), .req_rdy(req_rdy), .busy_set(busy_set),
        .busy_addr(busy_addr), .we(we), .dst_addr(dst_addr), .dst(dst), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        logic [NREQ-1:0] c;
        int s;
        if (!rst_n) return -1;
        c = req_vld;
`ifdef RF_WB_PRIO_EN
        if (m_cnt >= STARVE_MAX && (req_vld >> 1) != '0) c[0] = 1'b0;
        else if (req_vld[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            s = (m_ptr + k) % NREQ;
            if (c[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_rdy();
        int g;
        g = model_grant();
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    // One clock: model advances from the inputs seen before the edge
    task automatic tick();
        int g;
        logic r;
        logic [NREQ-1:0] v;
        logic [4:0] a;
        logic [31:0] d;
        logic bs;
        logic [4:0] ba;
        g = model_grant();
        r = rst_n; v = req_vld; bs = busy_set; ba = busy_addr;
        a = '0; d = '0;
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            d = req_data[g*DW +: DW];
        end
        @(posedge clk);
        #1;
        if (!r) begin
            m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_ptr = 0; m_cnt = 0;
        end else begin
            m_we = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                m_busy[a] = 1'b0;
                if (a != 0) begin
                    m_we = 1'b1; m_addr = a; m_data = d;
                end
            end
            if (bs && ba != 0) m_busy[ba] = 1'b1;
            if (g > 0) m_cnt = 0;
            else if ((v >> 1) != '0 && m_cnt < STARVE_MAX) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '1; busy_set = 1'b1; busy_addr = 5'd3;
        req_addr = '0; req_data = '0;
        #1;
        checks++;
        if (req_rdy !== '0) begin
            errors++; $display("FAIL reset_rdy: got %b expected 00", req_rdy);
        end
        tick(); tick();
        checks++;
        if (we !== 1'b0 || dst_addr !== '0 || dst !== '0 || busy !== '0) begin
            errors++;
            $display("FAIL reset_out: got we=%b addr=%0d dst=%h busy=%h expected all zero", we, dst_addr, dst, busy);
        end
        req_vld = '0; busy_set = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_vld = 2'b01; req_addr = {5'd0, 5'd5}; req_data = {32'h0, 32'hDEADBEEF};
        #1;
        checks++;
        if (req_rdy !== 2'b01 || req_rdy !== exp_rdy()) begin
            errors++; $display("FAIL single_rdy: got %b expected 01", req_rdy);
        end
        tick();
        req_vld = '0;
        checks++;
        if (we !== 1'b1 || dst_addr !== 5'd5 || dst !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write: got we=%b addr=%0d dst=%h expected 1/5/deadbeef", we, dst_addr, dst);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL single_idle: got we=%b expected 0", we);
        end
    endtask

    task automatic test_alternate();
        pulse_reset();
        req_vld = 2'b11; req_addr = {5'd2, 5'd1}; req_data = {32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_rdy !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL alt_rdy[%0d]: got %b expected %b", k, req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            tick();
            checks++;
            if (we !== 1'b1 || dst_addr !== ((k % 2 == 0) ? 5'd1 : 5'd2)) begin
                errors++; $display("FAIL alt_write[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", k, we, dst_addr, (k % 2 == 0) ? 1 : 2);
            end
        end
        req_vld = '0;
        tick();
    endtask

    task automatic test_scoreboard();
        busy_set = 1'b1; busy_addr = 5'd7;
        tick();
        busy_set = 1'b0;
        checks++;
        if (busy[7] !== 1'b1 || busy !== m_busy) begin
            errors++; $display("FAIL sb_set: got busy=%h expected %h", busy, m_busy);
        end
        req_vld = 2'b10; req_addr = {5'd7, 5'd0}; req_data = {32'hCAFE_0007, 32'h0};
        tick();
        req_vld = '0;
        checks++;
        if (we !== 1'b1 || dst_addr !== 5'd7 || busy[7] !== 1'b0) begin
            errors++; $display("FAIL sb_clear: got we=%b addr=%0d busy7=%b expected 1/7/0", we, dst_addr, busy[7]);
        end
    endtask

    task automatic test_same_cycle_and_r0();
        busy_set = 1'b1; busy_addr = 5'd9;
        req_vld = 2'b01; req_addr = {5'd0, 5'd9}; req_data = {32'h0, 32'h0000_0909};
        tick();
        busy_set = 1'b0; req_vld = '0;
        checks++;
        if (we !== 1'b1 || dst_addr !== 5'd9 || busy[9] !== 1'b1) begin
            errors++; $display("FAIL set_wins: got we=%b addr=%0d busy9=%b expected 1/9/1", we, dst_addr, busy[9]);
        end
        req_vld = 2'b01; req_addr = '0; req_data = {32'h0, 32'h1234_5678};
        busy_set = 1'b1; busy_addr = 5'd0;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL r0_rdy: got %b expected 01", req_rdy);
        end
        tick();
        req_vld = '0; busy_set = 1'b0;
        checks++;
        if (we !== 1'b0 || busy[0] !== 1'b0 || dst_addr !== 5'd9) begin
            errors++; $display("FAIL r0_write: got we=%b busy0=%b addr=%0d expected 0/0/9", we, busy[0], dst_addr);
        end
    endtask

    task automatic test_reset_mid();
        busy_set = 1'b1;
        for (int r = 8; r < 12; r++) begin
            busy_addr = 5'(r);
            tick();
        end
        busy_set = 1'b0;
        checks++;
        if (busy !== 32'h0000_0F00) begin
            errors++; $display("FAIL mid_busy: got %h expected 00000f00", busy);
        end
        req_vld = 2'b11; req_addr = {5'd4, 5'd3}; req_data = {32'h4444_4444, 32'h3333_3333};
        rst_n = 1'b0;
        tick();
        checks++;
        if (we !== 1'b0 || busy !== '0 || req_rdy !== '0) begin
            errors++; $display("FAIL mid_reset: got we=%b busy=%h rdy=%b expected 0/0/00", we, busy, req_rdy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL mid_first: got %b expected 01", req_rdy);
        end
        tick();
        req_vld = '0;
        checks++;
        if (we !== 1'b1 || dst_addr !== 5'd3 || dst !== 32'h3333_3333) begin
            errors++; $display("FAIL mid_write: got we=%b addr=%0d dst=%h expected 1/3/33333333", we, dst_addr, dst);
        end
        tick();
    endtask

`ifdef RF_WB_PRIO_EN
    task automatic test_prio();
        pulse_reset();
        req_vld = 2'b11; req_addr = {5'd6, 5'd5}; req_data = {32'h6, 32'h5};
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (req_rdy !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL prio_rdy[%0d]: got %b expected %b", k, req_rdy, (k % 5 == 4) ? 2'b10 : 2'b01);
            end
            tick();
        end
        req_vld = '0;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] e;
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    req_addr[i*AW +: AW] = 5'($urandom_range(0, 31));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            req_vld   = pend;
            busy_set  = ($urandom_range(0, 3) == 0);
            busy_addr = 5'($urandom_range(0, 31));
            rst_n     = ($urandom_range(0, 60) != 0);
            #1;
            e = exp_rdy();
            checks++;
            if (req_rdy !== e) begin
                errors++; $display("FAIL rand_rdy[%0d]: got %b expected %b", n, req_rdy, e);
            end
            tick();
            pend = pend & ~e;
            checks++;
            if (we !== m_we || dst_addr !== m_addr || dst !== m_data || busy !== m_busy) begin
                errors++;
                $display("FAIL rand_out[%0d]: got we=%b addr=%0d dst=%h busy=%h expected we=%b addr=%0d dst=%h busy=%h",
                         n, we, dst_addr, dst, busy, m_we, m_addr, m_data, m_busy);
            end
        end
        req_vld = '0; busy_set = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
`ifndef RF_WB_PRIO_EN
        test_alternate();
`else
        test_prio();
`endif
        test_scoreboard();
        test_same_cycle_and_r0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
